key_debounce: RTL

- Four-channel push-button conditioner placed directly upstream of the clock/time counter.
- Takes raw, bouncy, asynchronous active-low keys and synchronizes and debounces each one.
- Emits exactly one active-low, single-clock pulse per press, which is the form the counter expects on its key inputs. A level that is held low would toggle or increment the counter on every cycle.
- Optional auto-repeat on the time-set keys lets hours and minutes be advanced by holding a key.

---
 rtl/key_debounce.sv | 138 +++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// Four-channel key conditioner: 2-flop synchronizer, debounce FSM and optional
// auto-repeat per channel, producing one-clock active-low press pulses.
module key_debounce #(
  parameter int unsigned T_DEB       = 1_000_000,
  parameter int unsigned REPEAT_DLY  = 25_000_000,
  parameter int unsigned REPEAT_PER  = 10_000_000,
  parameter logic [3:0]  REPEAT_MASK = 4'b1110,
  parameter int unsigned CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  output logic [3:0] key_out,
  output logic [3:0] key_lvl
);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] PRESS_WAIT   = 3'd1;
  localparam logic [2:0] DOWN         = 3'd2;
  localparam logic [2:0] REPEAT       = 3'd3;
  localparam logic [2:0] RELEASE_WAIT = 3'd4;

  localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(T_DEB - 1);
  localparam logic [CNT_W-1:0] DLY_TERM = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_TERM = CNT_W'(REPEAT_PER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0] sync_reg;
  logic [3:0] key_s_reg;

  // Idle-high reset keeps a key held through reset from looking released-then-pressed early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= 4'hF;
      key_s_reg <= 4'hF;
    end else begin
      sync_reg  <= key_in;
      key_s_reg <= sync_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
      logic [2:0]       state_reg, state_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             pulse;
      logic             out_reg;
      logic             lvl_reg;

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pulse      = 1'b0;
        case (state_reg)
          IDLE: begin
            if (!key_s_reg[gi]) begin
              state_next = PRESS_WAIT;
              cnt_next   = '0;
            end
          end
          PRESS_WAIT: begin
            if (key_s_reg[gi]) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else if (cnt_reg == DEB_TERM) begin
              state_next = DOWN;
              cnt_next   = '0;
              pulse      = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
          DOWN: begin
            if (key_s_reg[gi]) begin
              state_next = RELEASE_WAIT;
              cnt_next   = '0;
            end else if (REPEAT_MASK[gi]) begin
              if (cnt_reg == DLY_TERM) begin
                state_next = REPEAT;
                cnt_next   = '0;
                pulse      = 1'b1;
              end else begin
                cnt_next = cnt_reg + CNT_ONE;
              end
            end else begin
              cnt_next = '0;
            end
          end
          REPEAT: begin
            if (key_s_reg[gi]) begin
              state_next = RELEASE_WAIT;
              cnt_next   = '0;
            end else if (cnt_reg == PER_TERM) begin
              cnt_next = '0;
              pulse    = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
          RELEASE_WAIT: begin
            // A re-press during release debounce restarts the repeat delay without a pulse.
            if (!key_s_reg[gi]) begin
              state_next = DOWN;
              cnt_next   = '0;
            end else if (cnt_reg == DEB_TERM) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
          default: begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          out_reg   <= 1'b1;
          lvl_reg   <= 1'b1;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          out_reg   <= ~pulse;
          lvl_reg   <= (state_next == IDLE) || (state_next == PRESS_WAIT);
        end
      end

      assign key_out[gi] = out_reg;
      assign key_lvl[gi] = lvl_reg;
    end
  endgenerate

endmodule
